// File: rtl/sram_pkg.sv
// Shared definitions for the banked single-port SRAM: scrub sequencer states,
// legal read-latency values and an index-width helper that never returns zero.
package sram_pkg;

    typedef enum logic {
        SCRUB_ST = 1'b0,
        READY_ST = 1'b1
    } scrub_state_e;

    localparam int RD_LAT_SHORT = 1;
    localparam int RD_LAT_LONG  = 2;

    // Width needed to index n items; at least 1 so single-entry cases stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// One bank of the banked SRAM: per-bit masked write and a registered read
// port that only updates on a read, so it holds its value otherwise.
module sram_bank
    import sram_pkg::*;
#(
    parameter int BITS  = 64,
    parameter int ROWS  = 4096,
    parameter int ROW_W = idx_width(ROWS)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [BITS-1:0]  wd,
    input  logic [BITS-1:0]  w_mask,
    output logic [BITS-1:0]  rd
);

    logic [BITS-1:0] mem [ROWS];

    // Bit-granular write: only bits with a set mask bit are updated.
    always_ff @(posedge clk) begin
        if (ce && we) begin
            for (int b = 0; b < BITS; b++) begin
                if (w_mask[b]) begin
                    mem[row][b] <= wd[b];
                end
            end
        end
    end

    // Registered read; untouched by writes and idle cycles.
    always_ff @(posedge clk) begin
        if (ce && !we) begin
            rd <= mem[row];
        end
    end

endmodule

// File: rtl/sram_banked_1rw.sv
// Banked single-port SRAM with bit-masked writes and 1- or 2-cycle reads.
// Optional power-up scrub enabled by defining SRAM_SCRUB_EN: after reset every
// row of every bank is zeroed in parallel while busy_out is held high.
// Bank selection uses addr / rows-per-bank, which reduces to the top address
// bits when WORD_DEPTH is a power of two and stays correct when it is not.
module sram_banked_1rw
    import sram_pkg::*;
#(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 16384,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = $clog2(WORD_DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    output logic                  busy_out
);

    localparam int ROWS   = WORD_DEPTH / NUM_BANKS;
    localparam int BANK_W = idx_width(NUM_BANKS);
    localparam int ROW_W  = idx_width(ROWS);

    logic              scrub_active;
    logic [ROW_W-1:0]  scrub_row;

    logic              in_range;
    logic              accept;
    logic              rd_accept;
    logic [BANK_W-1:0] bank_sel;
    logic [ROW_W-1:0]  row_sel;

    logic [NUM_BANKS-1:0] bank_ce;
    logic                 bank_we;
    logic [ROW_W-1:0]     bank_row;
    logic [BITS-1:0]      bank_wd;
    logic [BITS-1:0]      bank_mask;
    logic [BITS-1:0]      bank_rd [NUM_BANKS];

    logic              rd_v1_reg;
    logic [BANK_W-1:0] sel_reg;
    logic              zero_reg;
    logic [BITS-1:0]   rd_lat1;

    assign in_range  = (32'(addr_in) < 32'(WORD_DEPTH));
    assign accept    = ce_in && !busy_out;
    assign rd_accept = accept && !we_in;
    assign bank_sel  = BANK_W'(32'(addr_in) / ROWS);
    assign row_sel   = ROW_W'(32'(addr_in) % ROWS);

    // Shared bank write port: the scrubber overrides the user access while active.
    always_comb begin
        bank_we   = we_in;
        bank_row  = row_sel;
        bank_wd   = wd_in;
        bank_mask = w_mask_in;
        if (scrub_active) begin
            bank_we   = 1'b1;
            bank_row  = scrub_row;
            bank_wd   = '0;
            bank_mask = '1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            // Only the addressed bank sees an enable; out-of-range addresses reach none.
            assign bank_ce[gi] = scrub_active ||
                                 (accept && in_range && (bank_sel == BANK_W'(gi)));

            sram_bank #(
                .BITS  (BITS),
                .ROWS  (ROWS),
                .ROW_W (ROW_W)
            ) u_bank (
                .clk    (clk),
                .ce     (bank_ce[gi]),
                .we     (bank_we),
                .row    (bank_row),
                .wd     (bank_wd),
                .w_mask (bank_mask),
                .rd     (bank_rd[gi])
            );
        end
    endgenerate

    // Remember which bank answers the latest read and whether it must read as zero.
    // zero_reg resets high so rd_out is zero until the first read lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_reg <= 1'b0;
            sel_reg   <= '0;
            zero_reg  <= 1'b1;
        end else begin
            rd_v1_reg <= rd_accept;
            if (rd_accept) begin
                sel_reg  <= bank_sel;
                zero_reg <= !in_range;
            end
        end
    end

    // Bank read registers only change on a read to that bank, so this holds between reads.
    assign rd_lat1 = zero_reg ? '0 : bank_rd[sel_reg];

    generate
        if (RD_LATENCY == RD_LAT_LONG) begin : g_lat2
            logic [BITS-1:0] rd_q_reg;
            logic            rd_v2_reg;

            // Extra output stage: delay data and valid by one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q_reg  <= '0;
                    rd_v2_reg <= 1'b0;
                end else begin
                    rd_v2_reg <= rd_v1_reg;
                    if (rd_v1_reg) begin
                        rd_q_reg <= rd_lat1;
                    end
                end
            end

            assign rd_out       = rd_q_reg;
            assign rd_valid_out = rd_v2_reg;
        end else begin : g_lat1
            assign rd_out       = rd_lat1;
            assign rd_valid_out = rd_v1_reg;
        end
    endgenerate

`ifdef SRAM_SCRUB_EN
    scrub_state_e     state_reg;
    logic [ROW_W-1:0] scrub_cnt_reg;
    logic             busy_reg;

    // Scrub sequencer: zero one row of all banks per cycle, then release the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SCRUB_ST;
            scrub_cnt_reg <= '0;
            busy_reg      <= 1'b1;
        end else begin
            case (state_reg)
                SCRUB_ST: begin
                    if (scrub_cnt_reg == ROW_W'(ROWS - 1)) begin
                        state_reg <= READY_ST;
                        busy_reg  <= 1'b0;
                    end else begin
                        scrub_cnt_reg <= scrub_cnt_reg + ROW_W'(1);
                    end
                end
                default: begin
                    state_reg <= READY_ST;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_out     = busy_reg;
    assign scrub_active = busy_reg;
    assign scrub_row    = scrub_cnt_reg;
`else
    assign busy_out     = 1'b0;
    assign scrub_active = 1'b0;
    assign scrub_row    = '0;
`endif

endmodule
